jump_ctrl: RTL and testbench

- Control-flow initiator for the program counter. Decodes per-cycle control intent (jump, conditional branch, call, return, restart) into the PC's 5-bit jump_code / jump_address / return_address inputs.
- Owns the hardware return-address stack that feeds return_address.
- Sits between the instruction decoder and the PC; takes the PC's current instruction_address as feedback.

---
 rtl/jump_ctrl.sv | 134 +++++++++++++
 tb/tb_jump_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// Control-flow initiator for the program counter: decodes jump/branch/call/return/restart
// intent into PC jump codes and maintains the hardware return-address stack.
module jump_ctrl #(
    parameter int unsigned INSTR_ADDR_SIZE = 8,
    parameter int unsigned STACK_DEPTH     = 8
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          restart,
    input  logic                          instr_valid,
    input  logic                          is_jump,
    input  logic                          is_branch,
    input  logic                          cond_true,
    input  logic                          is_call,
    input  logic                          is_ret,
    input  logic [INSTR_ADDR_SIZE-1:0]    target,
    input  logic [INSTR_ADDR_SIZE-1:0]    instruction_address,
    output logic [4:0]                    jump_code,
    output logic [INSTR_ADDR_SIZE-1:0]    jump_address,
    output logic [INSTR_ADDR_SIZE-1:0]    return_address,
    output logic [$clog2(STACK_DEPTH):0]  depth,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned PtrW   = $clog2(STACK_DEPTH);
    localparam int unsigned DepthW = PtrW + 1;
    localparam logic [DepthW-1:0] DepthMax = DepthW'(STACK_DEPTH);

    typedef enum logic [4:0] {
        CodeReset   = 5'd0,
        CodeJump    = 5'd1,
        CodeRet     = 5'd2,
        CodeDefault = 5'd3
    } jump_code_e;

    logic [INSTR_ADDR_SIZE-1:0] stack_q [STACK_DEPTH];
    logic [INSTR_ADDR_SIZE-1:0] stack_d [STACK_DEPTH];
    logic [PtrW-1:0]            top_q, top_d;
    logic [DepthW-1:0]          depth_q, depth_d;
    logic                       overflow_q, overflow_d;
    logic                       underflow_q, underflow_d;
    logic                       start_pending_q, start_pending_d;

    jump_code_e                 code;
    logic                       do_push;
    logic                       do_pop;
    logic [INSTR_ADDR_SIZE-1:0] push_addr;

    assign push_addr = instruction_address + INSTR_ADDR_SIZE'(1);

    always_comb begin
        code    = CodeDefault;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (start_pending_q || restart) begin
            code = CodeReset;
        end else if (!instr_valid) begin
            code = CodeDefault;
        end else if (is_ret) begin
            code   = CodeRet;
            do_pop = 1'b1;
        end else if (is_call) begin
            code    = CodeJump;
            do_push = 1'b1;
        end else if (is_jump || (is_branch && cond_true)) begin
            code = CodeJump;
        end
    end

    assign jump_code      = code;
    assign jump_address   = target;
    assign return_address = (depth_q != '0) ? stack_q[top_q] : '0;
    assign depth          = depth_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

    always_comb begin
        stack_d         = stack_q;
        top_d           = top_q;
        depth_d         = depth_q;
        overflow_d      = overflow_q;
        underflow_d     = underflow_q;
        start_pending_d = 1'b0;
        if (restart) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_d[i] = '0;
            end
            top_d       = '0;
            depth_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else if (do_push) begin
            // Full stack wraps the top pointer onto the oldest entry.
            top_d          = top_q + PtrW'(1);
            stack_d[top_d] = push_addr;
            if (depth_q == DepthMax) begin
                overflow_d = 1'b1;
            end else begin
                depth_d = depth_q + DepthW'(1);
            end
        end else if (do_pop) begin
            if (depth_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                depth_d = depth_q - DepthW'(1);
                top_d   = top_q - PtrW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
            top_q           <= '0;
            depth_q         <= '0;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
            start_pending_q <= 1'b1;
        end else begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= stack_d[i];
            end
            top_q           <= top_d;
            depth_q         <= depth_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
            start_pending_q <= start_pending_d;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed vector table, async-reset sequence and
// randomized traffic against a queue-based return-stack model.
module tb_jump_ctrl;

    localparam int AW = 8;
    localparam int SD = 8;
    localparam int DW = $clog2(SD) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          restart = 1'b0, instr_valid = 1'b0, is_jump = 1'b0, is_branch = 1'b0;
    logic          cond_true = 1'b0, is_call = 1'b0, is_ret = 1'b0;
    logic [AW-1:0] target = '0, pc = '0;
    logic [4:0]    jump_code;
    logic [AW-1:0] jump_address, return_address;
    logic [DW-1:0] depth;
    logic          overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    jump_ctrl #(.INSTR_ADDR_SIZE(AW), .STACK_DEPTH(SD)) dut (
        .CLK                 (clk),
        .RST_N               (rst_n),
        .restart             (restart),
        .instr_valid         (instr_valid),
        .is_jump             (is_jump),
        .is_branch           (is_branch),
        .cond_true           (cond_true),
        .is_call             (is_call),
        .is_ret              (is_ret),
        .target              (target),
        .instruction_address (pc),
        .jump_code           (jump_code),
        .jump_address        (jump_address),
        .return_address      (return_address),
        .depth               (depth),
        .overflow            (overflow),
        .underflow           (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: newest return address at the back of the queue.
    logic [AW-1:0] mq[$];
    bit m_sp, m_ovf, m_unf;

    typedef struct {
        logic rs, v, j, b, c, ca, rt;
        logic [AW-1:0] tgt, pc;
        logic [4:0] code;
        logic [AW-1:0] ra;
        int dep;
        logic ov, un;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rs, v, j, b, c, ca, rt, input logic [AW-1:0] tg, p);
        restart = rs; instr_valid = v; is_jump = j; is_branch = b; cond_true = c;
        is_call = ca; is_ret = rt; target = tg; pc = p;
    endtask

    task automatic add(input logic rs, v, j, b, c, ca, rt, input logic [AW-1:0] tg, p,
                       input logic [4:0] code, input logic [AW-1:0] ra, input int dep,
                       input logic ov, un);
        vec_t e;
        e.rs = rs; e.v = v; e.j = j; e.b = b; e.c = c; e.ca = ca; e.rt = rt;
        e.tgt = tg; e.pc = p; e.code = code; e.ra = ra; e.dep = dep; e.ov = ov; e.un = un;
        vt.push_back(e);
    endtask

    function automatic logic [4:0] m_code();
        if (m_sp || restart) return 5'd0;
        if (!instr_valid) return 5'd3;
        if (is_ret) return 5'd2;
        if (is_call || is_jump || (is_branch && cond_true)) return 5'd1;
        return 5'd3;
    endfunction

    function automatic logic [AW-1:0] m_ra();
        if (mq.size() == 0) return '0;
        return mq[mq.size()-1];
    endfunction

    task automatic m_reset();
        mq.delete(); m_sp = 1'b1; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    task automatic m_update();
        logic [4:0] c;
        c = m_code();
        if (restart) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (c == 5'd2) begin
            if (mq.size() == 0) m_unf = 1'b1;
            else void'(mq.pop_back());
        end else if (c == 5'd1 && is_call) begin
            mq.push_back(AW'(pc + 1));
            if (mq.size() > SD) begin
                void'(mq.pop_front());
                m_ovf = 1'b1;
            end
        end
        m_sp = 1'b0;
    endtask

    task automatic m_check(input string tag);
        logic [4:0] c;
        c = m_code();
        chk({tag, ".code"}, 32'(jump_code), 32'(c));
        if (c == 5'd1) chk({tag, ".jaddr"}, 32'(jump_address), 32'(target));
        chk({tag, ".ret_addr"}, 32'(return_address), 32'(m_ra()));
        chk({tag, ".depth"}, 32'(depth), 32'(mq.size()));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    task automatic model_cycle(input string tag);
        @(negedge clk);
        m_check(tag);
        @(posedge clk);
        m_update();
        #1;
    endtask

    initial begin
        // Reset entry and call/return nesting.
        add(0,0,0,0,0,0,0, 8'h00, 8'h00, 5'd0, 8'h00, 0, 0, 0);
        add(0,0,0,0,0,0,0, 8'h00, 8'h00, 5'd3, 8'h00, 0, 0, 0);
        add(0,1,0,0,0,1,0, 8'h40, 8'h10, 5'd1, 8'h00, 1, 0, 0);
        add(0,1,0,0,0,1,0, 8'h80, 8'h42, 5'd1, 8'h11, 2, 0, 0);
        add(0,1,0,0,0,0,1, 8'h00, 8'h81, 5'd2, 8'h43, 1, 0, 0);
        add(0,1,0,0,0,0,1, 8'h00, 8'h44, 5'd2, 8'h11, 0, 0, 0);
        // Overflow: nine calls then eight returns.
        for (int i = 0; i < 9; i++)
            add(0,1,0,0,0,1,0, 8'h50, AW'(i), 5'd1, AW'(i), (i + 1 > SD) ? SD : i + 1, i == 8, 0);
        for (int k = 0; k < 8; k++)
            add(0,1,0,0,0,0,1, 8'h00, 8'h60, 5'd2, AW'(9 - k), 7 - k, 1, 0);
        add(1,0,0,0,0,0,0, 8'h00, 8'h00, 5'd0, 8'h00, 0, 0, 0);
        // Underflow and address wrap.
        add(0,1,0,0,0,0,1, 8'h00, 8'h70, 5'd2, 8'h00, 0, 0, 1);
        add(0,1,0,0,0,1,0, 8'h10, 8'hFF, 5'd1, 8'h00, 1, 0, 1);
        add(0,1,0,0,0,0,1, 8'h00, 8'h10, 5'd2, 8'h00, 0, 0, 1);
        add(1,0,0,0,0,0,0, 8'h00, 8'h00, 5'd0, 8'h00, 0, 0, 0);
        // Priority and branch.
        add(0,1,0,0,0,1,0, 8'h60, 8'h20, 5'd1, 8'h00, 1, 0, 0);
        add(0,1,0,0,0,1,1, 8'h60, 8'h55, 5'd2, 8'h21, 0, 0, 0);
        add(0,1,0,1,0,0,0, 8'h30, 8'h56, 5'd3, 8'h00, 0, 0, 0);
        add(0,1,0,1,1,0,0, 8'h30, 8'h57, 5'd1, 8'h00, 0, 0, 0);
        add(0,1,1,0,0,0,0, 8'h77, 8'h30, 5'd1, 8'h00, 0, 0, 0);
        add(0,0,0,0,0,1,0, 8'h77, 8'h78, 5'd3, 8'h00, 0, 0, 0);
        // Restart with a populated stack.
        add(0,1,0,0,0,1,0, 8'h90, 8'h01, 5'd1, 8'h00, 1, 0, 0);
        add(0,1,0,0,0,1,0, 8'h90, 8'h02, 5'd1, 8'h02, 2, 0, 0);
        add(0,1,0,0,0,1,0, 8'h90, 8'h03, 5'd1, 8'h03, 3, 0, 0);
        add(1,1,0,0,0,1,0, 8'h90, 8'h09, 5'd0, 8'h04, 0, 0, 0);
        add(0,0,0,0,0,0,0, 8'h00, 8'h00, 5'd3, 8'h00, 0, 0, 0);

        m_reset();
        @(negedge clk);
        chk("in_reset.code", 32'(jump_code), 32'd0);
        chk("in_reset.depth", 32'(depth), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vt[n]) begin
            set_in(vt[n].rs, vt[n].v, vt[n].j, vt[n].b, vt[n].c, vt[n].ca, vt[n].rt,
                   vt[n].tgt, vt[n].pc);
            @(negedge clk);
            chk($sformatf("vec%0d.code", n), 32'(jump_code), 32'(vt[n].code));
            chk($sformatf("vec%0d.jaddr", n), 32'(jump_address), 32'(vt[n].tgt));
            chk($sformatf("vec%0d.ret_addr", n), 32'(return_address), 32'(vt[n].ra));
            @(posedge clk);
            m_update();
            #1;
            chk($sformatf("vec%0d.depth", n), 32'(depth), 32'(vt[n].dep));
            chk($sformatf("vec%0d.ovf", n), 32'(overflow), 32'(vt[n].ov));
            chk($sformatf("vec%0d.unf", n), 32'(underflow), 32'(vt[n].un));
        end

        // Async reset mid-cycle with a populated stack.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 0, 1, 0, 8'hA0, AW'(8'hC0 + i));
            model_cycle("pre_arst");
        end
        set_in(0, 1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.code", 32'(jump_code), 32'd0);
        chk("arst.depth", 32'(depth), 32'd0);
        chk("arst.ret_addr", 32'(return_address), 32'd0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk);
        chk("post_arst0.code", 32'(jump_code), 32'd0);
        @(posedge clk);
        m_update();
        #1;
        @(negedge clk);
        chk("post_arst1.code", 32'(jump_code), 32'd3);
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 8,
                   $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
                   $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4,
                   $urandom_range(0, 9) < 3, AW'($urandom), AW'($urandom));
            model_cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
